// File: rtl/dilithium_pkg.sv
// Shared types and encodings for the Dilithium core arbiter.
package dilithium_pkg;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_START,
        ST_RUN,
        ST_GAP
    } state_e;

    // Operation modes understood by the core; 2'b11 is reserved and rejected.
    localparam logic [1:0] MODE_KEYGEN   = 2'b00;
    localparam logic [1:0] MODE_SIGN     = 2'b01;
    localparam logic [1:0] MODE_VERIFY   = 2'b10;
    localparam logic [1:0] MODE_RESERVED = 2'b11;

    // Security levels the core implements.
    localparam logic [2:0] SEC_LVL_2 = 3'd2;
    localparam logic [2:0] SEC_LVL_3 = 3'd3;
    localparam logic [2:0] SEC_LVL_5 = 3'd5;

    // A job is acceptable when its mode is not reserved and its level is supported.
    function automatic logic job_valid(input logic [1:0] mode, input logic [2:0] sec_lvl);
        return (mode != MODE_RESERVED) &&
               ((sec_lvl == SEC_LVL_2) || (sec_lvl == SEC_LVL_3) || (sec_lvl == SEC_LVL_5));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin picker: the pointer names the preferred requester.
module rr_arbiter (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant
);

    // Preferred requester wins if asking, otherwise the other one, one-hot result.
    always_comb begin
        grant = 2'b00;
        if (pointer == 1'b0) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
    end

endmodule

// File: rtl/dilithium_arbiter.sv
// Shares one Dilithium core between two requesters: round-robin pick, job
// validation, single-cycle start pulse, zero-latency stream muxing, and an
// idle gap between jobs.
module dilithium_arbiter
    import dilithium_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_start,
    input  logic [NUM_REQ-1:0][1:0]        req_mode,
    input  logic [NUM_REQ-1:0][2:0]        req_sec_lvl,
    output logic [NUM_REQ-1:0]             req_grant,
    output logic [NUM_REQ-1:0]             req_error,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]             req_valid_o,
    input  logic [NUM_REQ-1:0]             req_ready_o,
    output logic [NUM_REQ-1:0][DATA_W-1:0] req_data_o,
    output logic [NUM_REQ-1:0]             req_last,
    output logic                           core_start,
    output logic [1:0]                     core_mode,
    output logic [2:0]                     core_sec_lvl,
    output logic                           core_valid_i,
    input  logic                           core_ready_i,
    output logic [DATA_W-1:0]              core_data_i,
    input  logic                           core_valid_o,
    output logic                           core_ready_o,
    input  logic [DATA_W-1:0]              core_data_o,
    input  logic                           core_last
);

    state_e     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       win_q, win_d;
    logic [1:0] mode_q, mode_d;
    logic [2:0] sec_q, sec_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;

    logic [1:0] rr_grant;
    logic       job_ok;
    logic       run_last;

    rr_arbiter u_rr (
        .req     (req_start),
        .pointer (ptr_q),
        .grant   (rr_grant)
    );

    assign job_ok   = job_valid(mode_q, sec_q);
    // Final output beat handshaken by the winner; that beat still goes through.
    assign run_last = (state_q == ST_RUN) && core_valid_o && req_ready_o[win_q] && core_last;

    // State and job registers; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            win_q     <= 1'b0;
            mode_q    <= '0;
            sec_q     <= '0;
            gap_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            mode_q    <= mode_d;
            sec_q     <= sec_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state logic: pick, validate, start, run until last beat, then gap.
    always_comb begin
        // NOTE: every target gets a hold default first so no path infers a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        mode_d    = mode_q;
        sec_d     = sec_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_grant[0]) begin
                    win_d   = 1'b0;
                    mode_d  = req_mode[0];
                    sec_d   = req_sec_lvl[0];
                    state_d = ST_CHECK;
                end else if (rr_grant[1]) begin
                    win_d   = 1'b1;
                    mode_d  = req_mode[1];
                    sec_d   = req_sec_lvl[1];
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (job_ok) begin
                    state_d = ST_START;
                end else begin
                    ptr_d   = ~win_q;
                    state_d = ST_IDLE;
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (run_last) begin
                    ptr_d     = ~win_q;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: everything idles at zero except the winner's paths during a job.
    always_comb begin
        core_start   = 1'b0;
        core_mode    = '0;
        core_sec_lvl = '0;
        core_valid_i = 1'b0;
        core_data_i  = '0;
        core_ready_o = 1'b0;
        req_grant    = '0;
        req_error    = '0;
        req_ready_i  = '0;
        req_valid_o  = '0;
        req_data_o   = '0;
        req_last     = '0;
        case (state_q)
            ST_CHECK: begin
                if (!job_ok) req_error[win_q] = 1'b1;
            end
            ST_START: begin
                core_start       = 1'b1;
                req_grant[win_q] = 1'b1;
                core_mode        = mode_q;
                core_sec_lvl     = sec_q;
            end
            ST_RUN: begin
                req_grant[win_q]   = 1'b1;
                core_mode          = mode_q;
                core_sec_lvl       = sec_q;
                core_valid_i       = req_valid_i[win_q];
                core_data_i        = req_data_i[win_q];
                req_ready_i[win_q] = core_ready_i;
                req_valid_o[win_q] = core_valid_o;
                req_data_o[win_q]  = core_data_o;
                req_last[win_q]    = core_last;
                core_ready_o       = req_ready_o[win_q];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dilithium_arbiter.sv
// Directed bench for dilithium_arbiter: reset, single job, contention,
// rejection, back-pressure, gap timing and mid-job reset.
module tb_dilithium_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       req_start;
    logic [1:0][1:0]  req_mode;
    logic [1:0][2:0]  req_sec_lvl;
    logic [1:0]       req_valid_i;
    logic [1:0][63:0] req_data_i;
    logic [1:0]       req_ready_o;
    logic             core_ready_i;
    logic             core_valid_o;
    logic [63:0]      core_data_o;
    logic             core_last;

    logic [1:0]       req_grant, req_error, req_ready_i, req_valid_o, req_last;
    logic [1:0][63:0] req_data_o;
    logic             core_start, core_valid_i, core_ready_o;
    logic [1:0]       core_mode;
    logic [2:0]       core_sec_lvl;
    logic [63:0]      core_data_i;

    logic [1:0]       g3_req_grant, g3_req_error, g3_req_ready_i, g3_req_valid_o, g3_req_last;
    logic [1:0][63:0] g3_req_data_o;
    logic             g3_core_start, g3_core_valid_i, g3_core_ready_o;
    logic [1:0]       g3_core_mode;
    logic [2:0]       g3_core_sec_lvl;
    logic [63:0]      g3_core_data_i;

    dilithium_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_start(req_start), .req_mode(req_mode), .req_sec_lvl(req_sec_lvl),
        .req_grant(req_grant), .req_error(req_error),
        .req_valid_i(req_valid_i), .req_ready_i(req_ready_i), .req_data_i(req_data_i),
        .req_valid_o(req_valid_o), .req_ready_o(req_ready_o), .req_data_o(req_data_o),
        .req_last(req_last),
        .core_start(core_start), .core_mode(core_mode), .core_sec_lvl(core_sec_lvl),
        .core_valid_i(core_valid_i), .core_ready_i(core_ready_i), .core_data_i(core_data_i),
        .core_valid_o(core_valid_o), .core_ready_o(core_ready_o), .core_data_o(core_data_o),
        .core_last(core_last)
    );

    dilithium_arbiter #(.GAP_CYCLES(3)) dut_g3 (
        .clk(clk), .rst_n(rst_n),
        .req_start(req_start), .req_mode(req_mode), .req_sec_lvl(req_sec_lvl),
        .req_grant(g3_req_grant), .req_error(g3_req_error),
        .req_valid_i(req_valid_i), .req_ready_i(g3_req_ready_i), .req_data_i(req_data_i),
        .req_valid_o(g3_req_valid_o), .req_ready_o(req_ready_o), .req_data_o(g3_req_data_o),
        .req_last(g3_req_last),
        .core_start(g3_core_start), .core_mode(g3_core_mode), .core_sec_lvl(g3_core_sec_lvl),
        .core_valid_i(g3_core_valid_i), .core_ready_i(core_ready_i), .core_data_i(g3_core_data_i),
        .core_valid_o(core_valid_o), .core_ready_o(g3_core_ready_o), .core_data_o(core_data_o),
        .core_last(core_last)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Rising edges of core_start for each instance, sampled mid-cycle.
    int   starts = 0, g3_starts = 0;
    logic cs_prev = 1'b0, g3_prev = 1'b0;
    always @(negedge clk) begin
        if (core_start && !cs_prev) starts = starts + 1;
        if (g3_core_start && !g3_prev) g3_starts = g3_starts + 1;
        cs_prev = core_start;
        g3_prev = g3_core_start;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        req_start    = '0;
        req_mode     = '0;
        req_sec_lvl  = '0;
        req_valid_i  = '0;
        req_data_i   = '0;
        req_ready_o  = '0;
        core_ready_i = 1'b0;
        core_valid_o = 1'b0;
        core_data_o  = '0;
        core_last    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Called at posedge+1; returns at the sample point of the START cycle or on timeout.
    task automatic wait_start(input int max_cycles, output int n);
        n = 0;
        settle();
        while (!core_start && n < max_cycles) begin
            step();
            settle();
            n++;
        end
    endtask

    // Called in the START cycle; drives one last output beat in RUN, returns in GAP.
    task automatic finish_job();
        step();
        core_valid_o = 1'b1;
        core_last    = 1'b1;
        core_data_o  = 64'hF00D;
        req_ready_o  = 2'b11;
        step();
        core_valid_o = 1'b0;
        core_last    = 1'b0;
        req_ready_o  = 2'b00;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        req_start    = 2'b11;
        req_mode     = '0;
        req_sec_lvl  = {3'd2, 3'd2};
        req_valid_i  = 2'b11;
        req_data_i   = {64'h1111, 64'h2222};
        req_ready_o  = 2'b11;
        core_ready_i = 1'b1;
        core_valid_o = 1'b1;
        core_data_o  = 64'h3333;
        core_last    = 1'b1;
        step(); settle();
        tests_run++; if (core_start !== 1'b0) begin tests_failed++; $display("FAIL rst_core_start: got %0h exp 0", core_start); end
        tests_run++; if (req_grant !== 2'b00) begin tests_failed++; $display("FAIL rst_grant: got %0h exp 0", req_grant); end
        tests_run++; if (req_error !== 2'b00) begin tests_failed++; $display("FAIL rst_error: got %0h exp 0", req_error); end
        tests_run++; if (core_valid_i !== 1'b0 || core_data_i !== 64'h0) begin tests_failed++; $display("FAIL rst_core_in: got v=%0h d=%0h exp 0", core_valid_i, core_data_i); end
        tests_run++; if (core_ready_o !== 1'b0) begin tests_failed++; $display("FAIL rst_core_ready_o: got %0h exp 0", core_ready_o); end
        tests_run++; if (req_ready_i !== 2'b00) begin tests_failed++; $display("FAIL rst_req_ready_i: got %0h exp 0", req_ready_i); end
        tests_run++; if (req_valid_o !== 2'b00 || req_last !== 2'b00 || req_data_o !== '0) begin tests_failed++; $display("FAIL rst_req_out: got v=%0h l=%0h exp 0", req_valid_o, req_last); end
        tests_run++; if (core_mode !== 2'b00 || core_sec_lvl !== 3'b000) begin tests_failed++; $display("FAIL rst_core_cfg: got m=%0h s=%0h exp 0", core_mode, core_sec_lvl); end
        do_reset();
    endtask

    task automatic test_single_job();
        int base;
        do_reset();
        base = starts;
        req_start[0]   = 1'b1;
        req_mode[0]    = 2'b00;
        req_sec_lvl[0] = 3'd2;
        req_valid_i[0] = 1'b1;
        req_data_i[0]  = 64'hDEAD;
        core_ready_i   = 1'b1;
        settle();
        tests_run++; if (core_start !== 1'b0) begin tests_failed++; $display("FAIL sj_c1_start: got %0h exp 0", core_start); end
        tests_run++; if (req_ready_i !== 2'b00 || core_valid_i !== 1'b0) begin tests_failed++; $display("FAIL sj_pregrant_bp: got r=%0h v=%0h exp 0", req_ready_i, core_valid_i); end
        step(); settle();
        tests_run++; if (core_start !== 1'b0 || req_error !== 2'b00) begin tests_failed++; $display("FAIL sj_c2_check: got s=%0h e=%0h exp 0", core_start, req_error); end
        step(); settle();
        tests_run++; if (core_start !== 1'b1) begin tests_failed++; $display("FAIL sj_c3_start: got %0h exp 1", core_start); end
        tests_run++; if (req_grant !== 2'b01) begin tests_failed++; $display("FAIL sj_grant: got %0h exp 1", req_grant); end
        tests_run++; if (core_mode !== 2'b00 || core_sec_lvl !== 3'd2) begin tests_failed++; $display("FAIL sj_cfg: got m=%0h s=%0h exp m=0 s=2", core_mode, core_sec_lvl); end
        tests_run++; if (req_ready_i !== 2'b00) begin tests_failed++; $display("FAIL sj_start_bp: got %0h exp 0", req_ready_i); end
        req_start[0] = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            req_valid_i    = 2'b11;
            req_data_i[0]  = 64'hA000 + 64'(i);
            req_data_i[1]  = 64'h5555;
            settle();
            tests_run++; if (core_valid_i !== 1'b1 || core_data_i !== 64'hA000 + 64'(i)) begin tests_failed++; $display("FAIL sj_in_word%0d: got v=%0h d=%0h exp v=1 d=%0h", i, core_valid_i, core_data_i, 64'hA000 + 64'(i)); end
            tests_run++; if (req_ready_i !== 2'b01) begin tests_failed++; $display("FAIL sj_in_ready%0d: got %0h exp 1", i, req_ready_i); end
            step();
        end
        req_valid_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            core_valid_o = 1'b1;
            core_data_o  = 64'hB000 + 64'(i);
            core_last    = (i == 2);
            req_ready_o  = 2'b11;
            settle();
            tests_run++; if (req_valid_o !== 2'b01 || req_data_o[0] !== 64'hB000 + 64'(i) || req_data_o[1] !== 64'h0) begin tests_failed++; $display("FAIL sj_out_word%0d: got v=%0h d0=%0h d1=%0h exp v=1 d0=%0h d1=0", i, req_valid_o, req_data_o[0], req_data_o[1], 64'hB000 + 64'(i)); end
            tests_run++; if (req_last !== ((i == 2) ? 2'b01 : 2'b00) || core_ready_o !== 1'b1 || req_grant !== 2'b01) begin tests_failed++; $display("FAIL sj_out_ctl%0d: got l=%0h r=%0h g=%0h", i, req_last, core_ready_o, req_grant); end
            step();
        end
        core_valid_o = 1'b0;
        core_last    = 1'b0;
        settle();
        tests_run++; if (req_grant !== 2'b00 || req_valid_o !== 2'b00) begin tests_failed++; $display("FAIL sj_grant_fall: got g=%0h v=%0h exp 0", req_grant, req_valid_o); end
        repeat (6) step();
        tests_run++; if (starts - base !== 1) begin tests_failed++; $display("FAIL sj_start_count: got %0d exp 1", starts - base); end
    endtask

    task automatic test_contention();
        int n;
        int base;
        do_reset();
        base = starts;
        req_start      = 2'b11;
        req_mode[0]    = 2'b00; req_sec_lvl[0] = 3'd2;
        req_mode[1]    = 2'b01; req_sec_lvl[1] = 3'd3;
        wait_start(20, n);
        tests_run++; if (core_start !== 1'b1 || n !== 2) begin tests_failed++; $display("FAIL ct_first_start: got s=%0h n=%0d exp s=1 n=2", core_start, n); end
        tests_run++; if (req_grant !== 2'b01 || core_mode !== 2'b00) begin tests_failed++; $display("FAIL ct_first_winner: got g=%0h m=%0h exp g=1 m=0", req_grant, core_mode); end
        req_start[0] = 1'b0;
        finish_job();
        wait_start(20, n);
        tests_run++; if (req_grant !== 2'b10 || core_mode !== 2'b01 || core_sec_lvl !== 3'd3) begin tests_failed++; $display("FAIL ct_second_winner: got g=%0h m=%0h s=%0h exp g=2 m=1 s=3", req_grant, core_mode, core_sec_lvl); end
        tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL ct_default_gap: got %0d exp 3", n); end
        req_start[1] = 1'b0;
        finish_job();
        req_start = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_start(20, n);
            tests_run++; if (req_grant !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin tests_failed++; $display("FAIL ct_alt%0d: got %0h exp %0h", k, req_grant, (k % 2 == 0) ? 2'b01 : 2'b10); end
            finish_job();
        end
        req_start = 2'b00;
        repeat (4) step();
        tests_run++; if (starts - base !== 6) begin tests_failed++; $display("FAIL ct_start_count: got %0d exp 6", starts - base); end
    endtask

    task automatic test_rejection();
        int n;
        int base;
        do_reset();
        base = starts;
        req_start[1] = 1'b1; req_mode[1] = 2'b11; req_sec_lvl[1] = 3'd2;
        settle();
        tests_run++; if (req_error !== 2'b00) begin tests_failed++; $display("FAIL rj_mode_pre: got %0h exp 0", req_error); end
        step(); settle();
        tests_run++; if (req_error !== 2'b10 || req_grant !== 2'b00 || core_start !== 1'b0) begin tests_failed++; $display("FAIL rj_mode_pulse: got e=%0h g=%0h s=%0h exp e=2 g=0 s=0", req_error, req_grant, core_start); end
        req_start[1] = 1'b0;
        step(); settle();
        tests_run++; if (req_error !== 2'b00) begin tests_failed++; $display("FAIL rj_mode_width: got %0h exp 0", req_error); end
        req_start[1] = 1'b1; req_mode[1] = 2'b00; req_sec_lvl[1] = 3'd4;
        step(); settle();
        tests_run++; if (req_error !== 2'b10 || req_grant !== 2'b00) begin tests_failed++; $display("FAIL rj_sec_pulse: got e=%0h g=%0h exp e=2 g=0", req_error, req_grant); end
        req_start[1] = 1'b0;
        step(); settle();
        tests_run++; if (req_error !== 2'b00) begin tests_failed++; $display("FAIL rj_sec_width: got %0h exp 0", req_error); end
        repeat (4) step();
        tests_run++; if (starts - base !== 0 || req_grant !== 2'b00) begin tests_failed++; $display("FAIL rj_no_start: got starts=%0d g=%0h exp 0", starts - base, req_grant); end
        // Rejecting requester 0 must move the pointer to requester 1.
        req_start[0] = 1'b1; req_mode[0] = 2'b11; req_sec_lvl[0] = 3'd2;
        step(); settle();
        tests_run++; if (req_error !== 2'b01) begin tests_failed++; $display("FAIL rj_r0_pulse: got %0h exp 1", req_error); end
        req_start = 2'b11; req_mode[0] = 2'b00; req_sec_lvl[1] = 3'd5;
        step();
        wait_start(20, n);
        tests_run++; if (req_grant !== 2'b10 || core_sec_lvl !== 3'd5) begin tests_failed++; $display("FAIL rj_ptr_advance: got g=%0h s=%0h exp g=2 s=5", req_grant, core_sec_lvl); end
        req_start = 2'b00;
        finish_job();
    endtask

    task automatic test_backpressure();
        int n;
        int idx;
        int cyc;
        logic tog;
        logic [63:0] got[$];
        do_reset();
        req_start[0] = 1'b1; req_mode[0] = 2'b10; req_sec_lvl[0] = 3'd5;
        wait_start(20, n);
        req_start[0] = 1'b0;
        step();
        idx = 0; cyc = 0; tog = 1'b1;
        while (idx < 4 && cyc < 20) begin
            core_valid_o   = 1'b1;
            core_data_o    = 64'hC000 + 64'(idx);
            core_last      = (idx == 3);
            req_ready_o[0] = tog;
            settle();
            tests_run++; if (core_ready_o !== tog) begin tests_failed++; $display("FAIL bp_ready_mirror%0d: got %0h exp %0h", cyc, core_ready_o, tog); end
            tests_run++; if (req_valid_o !== 2'b01) begin tests_failed++; $display("FAIL bp_valid%0d: got %0h exp 1", cyc, req_valid_o); end
            if (req_valid_o[0] && req_ready_o[0]) got.push_back(req_data_o[0]);
            if (core_ready_o) idx++;
            tog = ~tog;
            cyc++;
            step();
        end
        core_valid_o = 1'b0; core_last = 1'b0; req_ready_o = 2'b00;
        tests_run++; if (cyc !== 7) begin tests_failed++; $display("FAIL bp_cycles: got %0d exp 7", cyc); end
        tests_run++; if (got.size() !== 4) begin tests_failed++; $display("FAIL bp_count: got %0d exp 4", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            tests_run++; if (got[i] !== 64'hC000 + 64'(i)) begin tests_failed++; $display("FAIL bp_order%0d: got %0h exp %0h", i, got[i], 64'hC000 + 64'(i)); end
        end
        settle();
        tests_run++; if (req_grant !== 2'b00) begin tests_failed++; $display("FAIL bp_grant_fall: got %0h exp 0", req_grant); end
    endtask

    task automatic test_back_to_back();
        int n;
        int base;
        do_reset();
        base = g3_starts;
        req_start = 2'b11;
        req_sec_lvl[0] = 3'd2; req_sec_lvl[1] = 3'd3;
        n = 0;
        settle();
        while (!g3_core_start && n < 20) begin step(); settle(); n++; end
        tests_run++; if (g3_core_start !== 1'b1 || g3_req_grant !== 2'b01) begin tests_failed++; $display("FAIL b2b_first: got s=%0h g=%0h exp s=1 g=1", g3_core_start, g3_req_grant); end
        step(); settle();
        tests_run++; if (g3_core_start !== 1'b0) begin tests_failed++; $display("FAIL b2b_start_width: got %0h exp 0", g3_core_start); end
        core_valid_o = 1'b1; core_last = 1'b1; core_data_o = 64'hE0; req_ready_o = 2'b11;
        step();
        core_valid_o = 1'b0; core_last = 1'b0; req_ready_o = 2'b00;
        settle();
        tests_run++; if (g3_req_grant !== 2'b00) begin tests_failed++; $display("FAIL b2b_grant_drop: got %0h exp 0", g3_req_grant); end
        n = 0;
        while (!g3_core_start && n < 30) begin n++; step(); settle(); end
        tests_run++; if (n !== 5) begin tests_failed++; $display("FAIL b2b_low_cycles: got %0d exp 5", n); end
        tests_run++; if (g3_req_grant !== 2'b10) begin tests_failed++; $display("FAIL b2b_second_winner: got %0h exp 2", g3_req_grant); end
        req_start = 2'b00;
        step();
        core_valid_o = 1'b1; core_last = 1'b1; req_ready_o = 2'b11;
        step();
        core_valid_o = 1'b0; core_last = 1'b0; req_ready_o = 2'b00;
        repeat (8) step();
        tests_run++; if (g3_starts - base !== 2) begin tests_failed++; $display("FAIL b2b_edges: got %0d exp 2", g3_starts - base); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        do_reset();
        req_start[0] = 1'b1; req_sec_lvl[0] = 3'd2;
        wait_start(20, n);
        req_start[0] = 1'b0;
        finish_job();
        req_start[1] = 1'b1; req_mode[1] = 2'b01; req_sec_lvl[1] = 3'd3;
        step();
        wait_start(20, n);
        tests_run++; if (req_grant !== 2'b10) begin tests_failed++; $display("FAIL mr_pre_winner: got %0h exp 2", req_grant); end
        req_start[1] = 1'b0;
        step();
        req_valid_i[1] = 1'b1; req_data_i[1] = 64'h77; core_ready_i = 1'b1;
        core_valid_o = 1'b1; core_data_o = 64'h88; req_ready_o = 2'b11;
        settle();
        tests_run++; if (core_valid_i !== 1'b1 || req_valid_o !== 2'b10) begin tests_failed++; $display("FAIL mr_running: got cv=%0h rv=%0h exp cv=1 rv=2", core_valid_i, req_valid_o); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (req_grant !== 2'b00 || req_error !== 2'b00 || core_start !== 1'b0) begin tests_failed++; $display("FAIL mr_abort_ctl: got g=%0h e=%0h s=%0h exp 0", req_grant, req_error, core_start); end
        tests_run++; if (core_valid_i !== 1'b0 || core_ready_o !== 1'b0 || req_ready_i !== 2'b00 || req_valid_o !== 2'b00 || req_data_o !== '0) begin tests_failed++; $display("FAIL mr_abort_stream: got cv=%0h cr=%0h ri=%0h vo=%0h exp 0", core_valid_i, core_ready_o, req_ready_i, req_valid_o); end
        tests_run++; if (core_mode !== 2'b00 || core_sec_lvl !== 3'd0) begin tests_failed++; $display("FAIL mr_abort_cfg: got m=%0h s=%0h exp 0", core_mode, core_sec_lvl); end
        step(); step();
        clear_inputs();
        rst_n = 1'b1;
        req_start = 2'b11; req_sec_lvl[0] = 3'd2; req_sec_lvl[1] = 3'd2;
        wait_start(20, n);
        tests_run++; if (core_start !== 1'b1 || req_grant !== 2'b01 || n !== 2) begin tests_failed++; $display("FAIL mr_after_release: got s=%0h g=%0h n=%0d exp s=1 g=1 n=2", core_start, req_grant, n); end
        req_start = 2'b00;
        finish_job();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_job();
        test_contention();
        test_rejection();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
